// File: rtl/bsg_cover_drain_arbiter.sv
// rtl/bsg_cover_drain_arbiter.sv - round-robin, burst-locked coverage drain arbiter
// Optional per-burst header beat: define BSG_COVER_DRAIN_ARBITER_HEADER_EN.
module bsg_cover_drain_arbiter #(
   parameter int num_p       = 4,
   parameter int width_p     = 32,
   parameter int max_beats_p = 256,
   parameter int lg_num_lp   = (num_p > 1) ? $clog2(num_p) : 1
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [num_p-1:0]         v_i,
   input  logic [num_p-1:0]         last_i,
   input  logic [num_p*width_p-1:0] data_i,
   output logic [num_p-1:0]         ready_o,
   output logic                     v_o,
   output logic                     last_o,
   output logic [width_p-1:0]       data_o,
   input  logic                     ready_i,
   output logic [lg_num_lp-1:0]     grant_id_o,
   output logic                     busy_o,
   output logic                     overflow_o,
   output logic [15:0]              bursts_o
);

   localparam int cnt_w_lp = $clog2(max_beats_p + 2);
   localparam logic [cnt_w_lp-1:0]  cnt_max_lp = cnt_w_lp'(max_beats_p);
   localparam logic [cnt_w_lp-1:0]  cnt_sat_lp = cnt_w_lp'(max_beats_p + 1);
   localparam logic [lg_num_lp-1:0] last_ch_lp = lg_num_lp'(num_p - 1);

   localparam logic [1:0] state_idle   = 2'd0;
   localparam logic [1:0] state_data   = 2'd2;
`ifdef BSG_COVER_DRAIN_ARBITER_HEADER_EN
   localparam logic [1:0] state_header = 2'd1;
`endif

   logic [1:0]           state_q, state_d;
   logic [lg_num_lp-1:0] rr_q, rr_d;
   logic [lg_num_lp-1:0] grant_q, grant_d;
   logic [cnt_w_lp-1:0]  cnt_q, cnt_d;
   logic                 overflow_q, overflow_d;
   logic [15:0]          bursts_q, bursts_d;
`ifdef BSG_COVER_DRAIN_ARBITER_HEADER_EN
   logic [width_p-lg_num_lp-1:0] seq_q, seq_d;
`endif

   logic                 pick_v;
   logic [lg_num_lp-1:0] pick_id;
   int                   idx;
   logic                 g_v;
   logic                 g_last;
   logic [width_p-1:0]   g_data;
   logic                 xfer_data;
   logic [lg_num_lp-1:0] rr_next;

   // First requester at or after the rr pointer, wrapping around.
   always_comb begin
      pick_v  = 1'b0;
      pick_id = '0;
      idx     = 0;
      for (int i = 0; i < num_p; i++) begin
         idx = (int'(rr_q) + i) % num_p;
         if (!pick_v && v_i[idx]) begin
            pick_v  = 1'b1;
            pick_id = lg_num_lp'(idx);
         end
      end
   end

   always_comb begin
      g_v       = v_i[grant_q];
      g_last    = last_i[grant_q];
      g_data    = data_i[int'(grant_q)*width_p +: width_p];
      xfer_data = (state_q == state_data) & g_v & ready_i;
      rr_next   = (grant_q == last_ch_lp) ? '0 : grant_q + 1'b1;
   end

   // Outputs are forced quiet while reset is held, not just after it lands.
   always_comb begin
      ready_o = '0;
      v_o     = 1'b0;
      last_o  = 1'b0;
      data_o  = '0;
      if (reset_n_i && state_q == state_data) begin
         v_o    = g_v;
         last_o = g_v & g_last;
         data_o = g_v ? g_data : '0;
         for (int k = 0; k < num_p; k++) begin
            ready_o[k] = ready_i & (grant_q == lg_num_lp'(k));
         end
      end
`ifdef BSG_COVER_DRAIN_ARBITER_HEADER_EN
      if (reset_n_i && state_q == state_header) begin
         v_o    = 1'b1;
         data_o = {seq_q, grant_q};
      end
`endif
   end

   always_comb begin
      busy_o     = reset_n_i & (state_q != state_idle);
      grant_id_o = busy_o ? grant_q : '0;
      overflow_o = overflow_q;
      bursts_o   = bursts_q;
   end

   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      grant_d    = grant_q;
      cnt_d      = cnt_q;
      overflow_d = overflow_q;
      bursts_d   = bursts_q;
`ifdef BSG_COVER_DRAIN_ARBITER_HEADER_EN
      seq_d      = seq_q;
`endif
      case (state_q)
         state_idle: begin
            if (pick_v) begin
               grant_d = pick_id;
`ifdef BSG_COVER_DRAIN_ARBITER_HEADER_EN
               state_d = state_header;
`else
               state_d = state_data;
`endif
            end
         end
`ifdef BSG_COVER_DRAIN_ARBITER_HEADER_EN
         state_header: begin
            if (ready_i) begin
               seq_d   = seq_q + 1'b1;
               state_d = state_data;
            end
         end
`endif
         state_data: begin
            if (xfer_data) begin
               if (g_last) begin
                  rr_d     = rr_next;
                  bursts_d = bursts_q + 16'd1;
                  cnt_d    = '0;
                  state_d  = state_idle;
               end else begin
                  // Overlong bursts are flagged but still drained to their last beat.
                  if (cnt_q == cnt_max_lp) overflow_d = 1'b1;
                  if (cnt_q != cnt_sat_lp) cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = state_idle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q    <= state_idle;
         rr_q       <= '0;
         grant_q    <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
         bursts_q   <= '0;
`ifdef BSG_COVER_DRAIN_ARBITER_HEADER_EN
         seq_q      <= '0;
`endif
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         grant_q    <= grant_d;
         cnt_q      <= cnt_d;
         overflow_q <= overflow_d;
         bursts_q   <= bursts_d;
`ifdef BSG_COVER_DRAIN_ARBITER_HEADER_EN
         seq_q      <= seq_d;
`endif
      end
   end

endmodule

// File: tb/tb_bsg_cover_drain_arbiter.sv
// tb/tb_bsg_cover_drain_arbiter.sv - directed self-checking bench for bsg_cover_drain_arbiter
module tb_bsg_cover_drain_arbiter;

   logic         clk;
   logic         reset_n;
   logic [3:0]   v_i, last_i, ready_o, ready_o2;
   logic [127:0] data_i;
   logic         v_o, last_o, ready_i, busy_o, overflow_o;
   logic [31:0]  data_o;
   logic [1:0]   grant_id_o;
   logic [15:0]  bursts_o;
   logic         v_o2, last_o2, busy_o2, overflow_o2;
   logic [31:0]  data_o2;
   logic [1:0]   grant_id_o2;
   logic [15:0]  bursts_o2;

   int n_checks = 0;
   int n_fail   = 0;

   int unsigned q_data[4][$];
   bit          q_last[4][$];
   bit          hold[4];
   int unsigned cap_data[$];
   bit          cap_last[$];
   int          cap_gnt[$];

   logic        s_v_o, s_last, s_busy, s_ovf, s_ovf2, s_ready_i;
   logic [31:0] s_data;
   logic [1:0]  s_gnt;
   logic [15:0] s_bursts;
   logic [3:0]  s_ready_o;

   bsg_cover_drain_arbiter #(.num_p(4), .width_p(32), .max_beats_p(256)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .last_i(last_i), .data_i(data_i),
      .ready_o(ready_o), .v_o(v_o), .last_o(last_o), .data_o(data_o), .ready_i(ready_i),
      .grant_id_o(grant_id_o), .busy_o(busy_o), .overflow_o(overflow_o), .bursts_o(bursts_o)
   );

   // Same stimulus, small burst limit, used for the overflow scenario.
   bsg_cover_drain_arbiter #(.num_p(4), .width_p(32), .max_beats_p(4)) dut_ovf (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .last_i(last_i), .data_i(data_i),
      .ready_o(ready_o2), .v_o(v_o2), .last_o(last_o2), .data_o(data_o2), .ready_i(ready_i),
      .grant_id_o(grant_id_o2), .busy_o(busy_o2), .overflow_o(overflow_o2), .bursts_o(bursts_o2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_inputs();
      for (int k = 0; k < 4; k++) begin
         if (q_data[k].size() > 0 && !hold[k]) begin
            v_i[k] = 1'b1;
            last_i[k] = q_last[k][0];
            data_i[k*32 +: 32] = q_data[k][0];
         end else begin
            v_i[k] = 1'b0;
            last_i[k] = 1'b0;
            data_i[k*32 +: 32] = '0;
         end
      end
   endtask

   task automatic add_burst(input int ch, input int n, input int unsigned base);
      for (int i = 0; i < n; i++) begin
         q_data[ch].push_back(base + i);
         q_last[ch].push_back(i == n - 1);
      end
   endtask

   // One clock: sample at negedge, pop accepted beats after the posedge.
   task automatic tick();
      logic [3:0] fire;
      @(negedge clk);
      s_v_o = v_o; s_last = last_o; s_data = data_o; s_gnt = grant_id_o; s_busy = busy_o;
      s_ovf = overflow_o; s_ovf2 = overflow_o2; s_bursts = bursts_o;
      s_ready_o = ready_o; s_ready_i = ready_i;
      if (v_o && ready_i) begin
         cap_data.push_back(data_o);
         cap_last.push_back(last_o);
         cap_gnt.push_back(int'(grant_id_o));
      end
      fire = v_i & ready_o;
      @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         if (fire[k]) begin
            void'(q_data[k].pop_front());
            void'(q_last[k].pop_front());
         end
      end
      drive_inputs();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         q_data[k].delete();
         q_last[k].delete();
         hold[k] = 1'b0;
      end
      cap_data.delete(); cap_last.delete(); cap_gnt.delete();
      drive_inputs();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      ready_i = 1'b1;
      v_i = 4'hF; last_i = 4'hF; data_i = {4{32'hDEADBEEF}};
      @(posedge clk);
      @(posedge clk);
      #1;
      n_checks++; if (v_o !== 1'b0) begin n_fail++; $display("FAIL reset_v_o: got %b exp 0", v_o); end
      n_checks++; if (last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last_o: got %b exp 0", last_o); end
      n_checks++; if (ready_o !== 4'h0) begin n_fail++; $display("FAIL reset_ready_o: got %h exp 0", ready_o); end
      n_checks++; if (data_o !== 32'h0) begin n_fail++; $display("FAIL reset_data_o: got %h exp 0", data_o); end
      n_checks++; if (grant_id_o !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d exp 0", grant_id_o); end
      n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy_o); end
      n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b exp 0", overflow_o); end
      n_checks++; if (bursts_o !== 16'd0) begin n_fail++; $display("FAIL reset_bursts: got %0d exp 0", bursts_o); end
   endtask

   task automatic test_single_burst();
      do_reset();
      add_burst(2, 3, 32'hA);
      drive_inputs();
      tick();
      n_checks++; if (s_v_o !== 1'b0) begin n_fail++; $display("FAIL single_idle_v_o: got %b exp 0", s_v_o); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (s_v_o !== 1'b1) begin n_fail++; $display("FAIL single_v_o beat %0d: got %b exp 1", i, s_v_o); end
         n_checks++; if (s_data !== 32'hA + i) begin n_fail++; $display("FAIL single_data beat %0d: got %h exp %h", i, s_data, 32'hA + i); end
         n_checks++; if (s_last !== (i == 2)) begin n_fail++; $display("FAIL single_last beat %0d: got %b exp %b", i, s_last, i == 2); end
         n_checks++; if (s_gnt !== 2'd2) begin n_fail++; $display("FAIL single_grant beat %0d: got %0d exp 2", i, s_gnt); end
         n_checks++; if (s_ready_o !== 4'b0100) begin n_fail++; $display("FAIL single_ready_o beat %0d: got %b exp 0100", i, s_ready_o); end
      end
      tick();
      n_checks++; if (s_bursts !== 16'd1) begin n_fail++; $display("FAIL single_bursts: got %0d exp 1", s_bursts); end
      n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b exp 0", s_busy); end
   endtask

   task automatic test_fairness();
      int          exp_g[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
      int unsigned exp_d[10] = '{32'h000, 32'h001, 32'h100, 32'h101, 32'h200,
                                 32'h201, 32'h300, 32'h301, 32'h010, 32'h011};
      do_reset();
      add_burst(0, 2, 32'h000);
      add_burst(0, 2, 32'h010);
      add_burst(1, 2, 32'h100);
      add_burst(2, 2, 32'h200);
      add_burst(3, 2, 32'h300);
      drive_inputs();
      for (int c = 0; c < 60 && cap_data.size() < 10; c++) tick();
      n_checks++;
      if (cap_data.size() != 10) begin
         n_fail++; $display("FAIL fair_count: got %0d beats exp 10", cap_data.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            n_checks++; if (cap_gnt[i] != exp_g[i]) begin n_fail++; $display("FAIL fair_grant %0d: got %0d exp %0d", i, cap_gnt[i], exp_g[i]); end
            n_checks++; if (cap_data[i] != exp_d[i]) begin n_fail++; $display("FAIL fair_data %0d: got %h exp %h", i, cap_data[i], exp_d[i]); end
            n_checks++; if (cap_last[i] != (i % 2 == 1)) begin n_fail++; $display("FAIL fair_last %0d: got %b exp %b", i, cap_last[i], i % 2 == 1); end
         end
      end
   endtask

   task automatic test_backpressure();
      int unsigned exp_d[5] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h200};
      int          exp_g[5] = '{1, 1, 1, 1, 2};
      bit          exp_l[5] = '{0, 0, 0, 1, 1};
      do_reset();
      add_burst(1, 4, 32'h100);
      add_burst(2, 1, 32'h200);
      drive_inputs();
      for (int c = 0; c < 30 && cap_data.size() < 5; c++) begin
         ready_i = (c < 2) ? 1'b1 : (c % 2 == 0);
         tick();
         if (s_busy && s_gnt == 2'd1) begin
            n_checks++; if (s_ready_o[1] !== s_ready_i) begin n_fail++; $display("FAIL bp_ready_track c%0d: got %b exp %b", c, s_ready_o[1], s_ready_i); end
            n_checks++; if ((s_ready_o & 4'b1101) !== 4'b0000) begin n_fail++; $display("FAIL bp_other_ready c%0d: got %b exp 0", c, s_ready_o); end
         end
      end
      ready_i = 1'b1;
      n_checks++;
      if (cap_data.size() != 5) begin
         n_fail++; $display("FAIL bp_count: got %0d beats exp 5", cap_data.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_checks++; if (cap_data[i] != exp_d[i] || cap_gnt[i] != exp_g[i] || cap_last[i] != exp_l[i]) begin
               n_fail++; $display("FAIL bp_beat %0d: got %h/g%0d/l%b exp %h/g%0d/l%b", i, cap_data[i], cap_gnt[i], cap_last[i], exp_d[i], exp_g[i], exp_l[i]);
            end
         end
      end
   endtask

   task automatic test_stall();
      int unsigned exp_d[6] = '{32'h300, 32'h301, 32'h302, 32'h303, 32'h010, 32'h011};
      int          exp_g[6] = '{3, 3, 3, 3, 0, 0};
      bit          exp_l[6] = '{0, 0, 0, 1, 0, 1};
      do_reset();
      add_burst(3, 4, 32'h300);
      drive_inputs();
      tick();
      tick();
      hold[3] = 1'b1;
      add_burst(0, 2, 32'h010);
      drive_inputs();
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++; if (s_v_o !== 1'b0) begin n_fail++; $display("FAIL stall_v_o c%0d: got %b exp 0", c, s_v_o); end
         n_checks++; if (s_gnt !== 2'd3 || s_busy !== 1'b1) begin n_fail++; $display("FAIL stall_grant c%0d: got g%0d busy %b exp g3 busy 1", c, s_gnt, s_busy); end
         n_checks++; if (s_ready_o[0] !== 1'b0) begin n_fail++; $display("FAIL stall_ch0_ready c%0d: got %b exp 0", c, s_ready_o[0]); end
      end
      hold[3] = 1'b0;
      drive_inputs();
      for (int c = 0; c < 30 && cap_data.size() < 6; c++) tick();
      n_checks++;
      if (cap_data.size() != 6) begin
         n_fail++; $display("FAIL stall_count: got %0d beats exp 6", cap_data.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_checks++; if (cap_data[i] != exp_d[i] || cap_gnt[i] != exp_g[i] || cap_last[i] != exp_l[i]) begin
               n_fail++; $display("FAIL stall_beat %0d: got %h/g%0d/l%b exp %h/g%0d/l%b", i, cap_data[i], cap_gnt[i], cap_last[i], exp_d[i], exp_g[i], exp_l[i]);
            end
         end
      end
   endtask

   task automatic test_overflow();
      do_reset();
      add_burst(1, 6, 32'h600);
      drive_inputs();
      for (int i = 0; i < 8; i++) begin
         tick();
         n_checks++; if (s_ovf2 !== (i >= 6)) begin n_fail++; $display("FAIL ovf_flag tick %0d: got %b exp %b", i, s_ovf2, i >= 6); end
      end
      n_checks++; if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_big_limit: got %b exp 0", s_ovf); end
      n_checks++;
      if (cap_data.size() != 6) begin
         n_fail++; $display("FAIL ovf_count: got %0d beats exp 6", cap_data.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_checks++; if (cap_data[i] != 32'h600 + i || cap_last[i] != (i == 5)) begin
               n_fail++; $display("FAIL ovf_beat %0d: got %h/l%b exp %h/l%b", i, cap_data[i], cap_last[i], 32'h600 + i, i == 5);
            end
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      add_burst(2, 1, 32'h200);
      drive_inputs();
      tick(); tick(); tick();
      n_checks++; if (s_bursts !== 16'd1) begin n_fail++; $display("FAIL rst_pre_bursts: got %0d exp 1", s_bursts); end
      add_burst(1, 4, 32'h700);
      drive_inputs();
      tick();
      tick();
      reset_n = 1'b0;
      tick();
      n_checks++; if (s_v_o !== 1'b0) begin n_fail++; $display("FAIL rst_during_v_o: got %b exp 0", s_v_o); end
      reset_n = 1'b1;
      q_data[1].delete();
      q_last[1].delete();
      add_burst(0, 1, 32'h0A0);
      add_burst(3, 1, 32'h3A0);
      drive_inputs();
      tick();
      n_checks++; if (s_v_o !== 1'b0) begin n_fail++; $display("FAIL rst_after_v_o: got %b exp 0", s_v_o); end
      n_checks++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL rst_after_busy: got %b exp 0", s_busy); end
      n_checks++; if (s_bursts !== 16'd0) begin n_fail++; $display("FAIL rst_after_bursts: got %0d exp 0", s_bursts); end
      n_checks++; if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_after_overflow: got %b exp 0", s_ovf); end
      tick();
      n_checks++; if (s_gnt !== 2'd0 || s_v_o !== 1'b1) begin n_fail++; $display("FAIL rst_rr_restart: got g%0d v%b exp g0 v1", s_gnt, s_v_o); end
      n_checks++; if (s_data !== 32'h0A0) begin n_fail++; $display("FAIL rst_rr_data: got %h exp 0a0", s_data); end
   endtask

   initial begin
      reset_n = 1'b0;
      ready_i = 1'b1;
      v_i = '0; last_i = '0; data_i = '0;
      test_reset();
      test_single_burst();
      test_fairness();
      test_backpressure();
      test_stall();
      test_overflow();
      test_reset_mid_burst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
